// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: player position/heading controller for the maze renderer.
// Walls come from an external synchronous map ROM (1-cycle read latency).
// Key rising edges become turn/move actions; moves are checked for walls and
// map bounds before commit. Optional build macro: AUTO_REPEAT_EN (held
// forward/back key re-fires the last move every REPEAT_CYCLES cycles).
//
// Handshake: there is no valid/ready pair. key_pressed is a level bus; an
// action is taken only on a rising edge seen in IDLE while at_exit is low, and
// edges arriving at any other time are dropped, never queued. map_rd_x/y is a
// registered address; map_rd_wall must answer that address one cycle later.
module maze_player_ctrl #(
  parameter int MAP_W         = 11,
  parameter int MAP_H         = 21,
  parameter int COORD_W       = 6,
  parameter int INIT_X        = 5,
  parameter int INIT_Y        = 2,
  parameter int INIT_DIR      = 3,
  parameter int EXIT_X        = 9,
  parameter int EXIT_Y        = 19,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [3:0]         key_pressed,
  output logic [COORD_W-1:0] map_rd_x,
  output logic [COORD_W-1:0] map_rd_y,
  input  logic               map_rd_wall,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic [1:0]         direction,
  output logic               busy,
  output logic               refresh,
  output logic               bump,
  output logic               at_exit,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_CHECK  = 2'd2
  } state_t;

  localparam logic signed [COORD_W-1:0] LP_MAP_W  = COORD_W'(MAP_W);
  localparam logic signed [COORD_W-1:0] LP_MAP_H  = COORD_W'(MAP_H);
  localparam logic signed [COORD_W-1:0] LP_INIT_X = COORD_W'(INIT_X);
  localparam logic signed [COORD_W-1:0] LP_INIT_Y = COORD_W'(INIT_Y);
  localparam logic signed [COORD_W-1:0] LP_EXIT_X = COORD_W'(EXIT_X);
  localparam logic signed [COORD_W-1:0] LP_EXIT_Y = COORD_W'(EXIT_Y);

  state_t                     r_state, w_state_n;
  logic [3:0]                 r_key_q;
  logic signed [COORD_W-1:0]  r_px, r_py, r_tx, r_ty;
  logic signed [COORD_W-1:0]  w_px_n, w_py_n, w_tx_n, w_ty_n;
  logic [COORD_W-1:0]         r_rd_x, r_rd_y, w_rd_x_n, w_rd_y_n;
  logic [1:0]                 r_dir, w_dir_n;
  logic                       r_refresh, r_bump, r_at_exit;
  logic                       w_refresh_n, w_bump_n;
  logic [3:0]                 w_edge, w_edge_eff, w_take;
  logic signed [COORD_W-1:0]  w_fx, w_fy;
  logic                       w_blocked;

  assign w_edge = key_pressed & ~r_key_q;

`ifdef AUTO_REPEAT_EN
  localparam int RC_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RC_W-1:0] LP_RC_MAX = RC_W'(REPEAT_CYCLES - 1);

  logic [RC_W-1:0] r_rep_cnt;
  logic [1:0]      r_last_move;
  logic            w_held_fwd, w_held_back, w_rep_en, w_rep_hit;

  assign w_held_fwd  = key_pressed[1] & r_last_move[1];
  assign w_held_back = key_pressed[0] & r_last_move[0];
  assign w_rep_en    = (r_state == S_IDLE) & ~r_at_exit &
                       (w_held_fwd | w_held_back) & (w_edge == 4'b0000);
  assign w_rep_hit   = w_rep_en & (r_rep_cnt == LP_RC_MAX);
  assign w_edge_eff  = w_edge | {2'b00, w_held_fwd & w_rep_hit,
                                 w_held_back & ~w_held_fwd & w_rep_hit};

  // Repeat counter runs only while the last move key is held in IDLE
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rep_cnt   <= '0;
      r_last_move <= 2'b00;
    end else begin
      if (!w_rep_en || w_rep_hit) r_rep_cnt <= '0;
      else                        r_rep_cnt <= r_rep_cnt + 1'b1;
      if (w_take != 4'b0000) r_last_move <= w_take[1:0];
    end
  end
`else
  assign w_edge_eff = w_edge;
`endif

  // Forward unit vector for the current heading (north is -y)
  always_comb begin
    w_fx = '0;
    w_fy = '0;
    case (r_dir)
      2'd0:    w_fx = COORD_W'(1);
      2'd1:    w_fy = -COORD_W'(1);
      2'd2:    w_fx = -COORD_W'(1);
      default: w_fy = COORD_W'(1);
    endcase
  end

  // Priority pick of one action: left > right > forward > back
  always_comb begin
    w_take = 4'b0000;
    if (r_state == S_IDLE && !r_at_exit) begin
      if      (w_edge_eff[3]) w_take = 4'b1000;
      else if (w_edge_eff[2]) w_take = 4'b0100;
      else if (w_edge_eff[1]) w_take = 4'b0010;
      else if (w_edge_eff[0]) w_take = 4'b0001;
    end
  end

  // Out-of-range targets are blocked regardless of what the ROM returned
  assign w_blocked = map_rd_wall | r_tx[COORD_W-1] | r_ty[COORD_W-1] |
                     (r_tx >= LP_MAP_W) | (r_ty >= LP_MAP_H);

  // Next-state and datapath next values
  always_comb begin
    w_state_n   = r_state;
    w_px_n      = r_px;
    w_py_n      = r_py;
    w_dir_n     = r_dir;
    w_tx_n      = r_tx;
    w_ty_n      = r_ty;
    w_rd_x_n    = r_rd_x;
    w_rd_y_n    = r_rd_y;
    w_refresh_n = 1'b0;
    w_bump_n    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take[3]) begin
          w_dir_n     = r_dir + 2'd1;
          w_refresh_n = 1'b1;
        end else if (w_take[2]) begin
          w_dir_n     = r_dir - 2'd1;
          w_refresh_n = 1'b1;
        end else if (w_take[1] || w_take[0]) begin
          w_tx_n    = w_take[1] ? (r_px + w_fx) : (r_px - w_fx);
          w_ty_n    = w_take[1] ? (r_py + w_fy) : (r_py - w_fy);
          w_rd_x_n  = w_tx_n;
          w_rd_y_n  = w_ty_n;
          w_state_n = S_LOOKUP;
        end
      end
      S_LOOKUP: w_state_n = S_CHECK;
      S_CHECK: begin
        if (w_blocked) begin
          w_bump_n = 1'b1;
        end else begin
          w_px_n      = r_tx;
          w_py_n      = r_ty;
          w_refresh_n = 1'b1;
        end
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any move in flight
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_key_q   <= 4'b0000;
      r_px      <= LP_INIT_X;
      r_py      <= LP_INIT_Y;
      r_dir     <= 2'(INIT_DIR);
      r_tx      <= '0;
      r_ty      <= '0;
      r_rd_x    <= '0;
      r_rd_y    <= '0;
      r_refresh <= 1'b0;
      r_bump    <= 1'b0;
      r_at_exit <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_key_q   <= key_pressed;
      r_px      <= w_px_n;
      r_py      <= w_py_n;
      r_dir     <= w_dir_n;
      r_tx      <= w_tx_n;
      r_ty      <= w_ty_n;
      r_rd_x    <= w_rd_x_n;
      r_rd_y    <= w_rd_y_n;
      r_refresh <= w_refresh_n;
      r_bump    <= w_bump_n;
      r_at_exit <= r_at_exit | ((r_px == LP_EXIT_X) && (r_py == LP_EXIT_Y));
    end
  end

  assign map_rd_x  = r_rd_x;
  assign map_rd_y  = r_rd_y;
  assign px        = r_px;
  assign py        = r_py;
  assign direction = r_dir;
  assign busy      = (r_state != S_IDLE);
  assign refresh   = r_refresh;
  assign bump      = r_bump;
  assign at_exit   = r_at_exit;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Testbench for maze_player_ctrl: bench-side map ROM, reference model of the
// player, scoreboard queue of expected {px, py, direction, refresh, bump}.
module tb_maze_player_ctrl;

  localparam int MAP_W = 11;
  localparam int MAP_H = 21;

  // Clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] key_pressed = 4'b0000;
  logic [5:0] map_rd_x, map_rd_y, px, py;
  logic       map_rd_wall;
  logic [1:0] direction, dbg_state;
  logic       busy, refresh, bump, at_exit;

  maze_player_ctrl dut (
    .clk(clk), .rstn(rstn), .key_pressed(key_pressed),
    .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_rd_wall(map_rd_wall),
    .px(px), .py(py), .direction(direction), .busy(busy),
    .refresh(refresh), .bump(bump), .at_exit(at_exit), .dbg_state(dbg_state)
  );

  // Bench map ROM: bit x of row y is the wall at (x, y)
  logic [MAP_W-1:0] tb_map [MAP_H];

  function automatic logic rom_bit(input logic [5:0] ax, input logic [5:0] ay);
    int x, y;
    x = int'($signed(ax));
    y = int'($signed(ay));
    if (x < 0 || y < 0 || x >= MAP_W || y >= MAP_H) return 1'b0;
    return tb_map[y][x];
  endfunction

  always @(posedge clk) map_rd_wall <= rom_bit(map_rd_x, map_rd_y);

  // Scoreboard state and reference model
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int m_px, m_py, m_dir;

  task automatic model_step(input logic [3:0] v, output logic [15:0] e, output int el);
    int fx, fy, tx, ty, s;
    logic blk, rf, bp;
    rf = 1'b0; bp = 1'b0; el = 1; fx = 0; fy = 0;
    if (v[3]) begin
      m_dir = (m_dir + 1) % 4; rf = 1'b1;
    end else if (v[2]) begin
      m_dir = (m_dir + 3) % 4; rf = 1'b1;
    end else if (v[1] || v[0]) begin
      el = 3;
      case (m_dir)
        0: fx = 1;
        1: fy = -1;
        2: fx = -1;
        default: fy = 1;
      endcase
      s  = v[1] ? 1 : -1;
      tx = m_px + s * fx;
      ty = m_py + s * fy;
      if (tx < 0 || ty < 0 || tx >= MAP_W || ty >= MAP_H) blk = 1'b1;
      else blk = tb_map[ty][tx];
      if (blk) bp = 1'b1;
      else begin
        m_px = tx; m_py = ty; rf = 1'b1;
      end
    end
    e = {m_px[5:0], m_py[5:0], m_dir[1:0], rf, bp};
  endtask

  // Driver tasks
  task automatic press(input logic [3:0] v);
    @(posedge clk); #1 key_pressed = v;
    @(posedge clk); #1 key_pressed = 4'b0000;
  endtask

  task automatic wait_result(output logic [15:0] obs, output int lat);
    logic done;
    done = 1'b0; lat = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (refresh || bump) done = 1'b1;
    end
    if (!done) lat = -1;
    obs = {px, py, direction, refresh, bump};
  endtask

  task automatic act(input logic [3:0] v, output logic [15:0] obs,
                     output logic [15:0] exp_v, output int lat, output int el);
    logic [15:0] e;
    model_step(v, e, el);
    exp_q.push_back(e);
    press(v);
    wait_result(obs, lat);
    exp_v = exp_q.pop_front();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rstn = 1'b0; key_pressed = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    m_px = 5; m_py = 2; m_dir = 3;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [19:0] o;
    do_reset();
    o = {px, py, direction, busy, refresh, bump, at_exit};
    n_cmp++;
    if (o !== {6'd5, 6'd2, 2'd3, 4'b0000}) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", o, {6'd5, 6'd2, 2'd3, 4'b0000});
    end
    n_cmp++;
    if ({map_rd_x, map_rd_y} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_map_rd: got %h expected 000", {map_rd_x, map_rd_y});
    end
  endtask

  // Forward from (5,2) heading south, checked cycle by cycle
  task automatic test_move_latency();
    logic [15:0] e;
    int el;
    model_step(4'b0010, e, el);
    exp_q.push_back(e);
    @(posedge clk); #1 key_pressed = 4'b0010;
    @(posedge clk); #1 key_pressed = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if ({map_rd_x, map_rd_y, busy, px, py} !== {6'd5, 6'd3, 1'b1, 6'd5, 6'd2}) begin
      n_err++;
      $display("FAIL move_lookup: got rd=(%0d,%0d) busy=%b pos=(%0d,%0d) expected rd=(5,3) busy=1 pos=(5,2)",
               map_rd_x, map_rd_y, busy, px, py);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, refresh, bump} !== 3'b100) begin
      n_err++;
      $display("FAIL move_check: got busy/refresh/bump=%b expected 100", {busy, refresh, bump});
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++;
    if ({px, py, direction, refresh, bump} !== e || busy !== 1'b0) begin
      n_err++;
      $display("FAIL move_commit: got %h busy=%b expected %h busy=0",
               {px, py, direction, refresh, bump}, busy, e);
    end
    @(negedge clk);
    n_cmp++;
    if (refresh !== 1'b0) begin
      n_err++;
      $display("FAIL move_refresh_width: got refresh=%b expected 0", refresh);
    end
  endtask

  // Turns, including a right+forward chord where only the turn survives
  task automatic test_turns();
    logic [3:0] seq [3];
    logic [15:0] o, e;
    int l, el, extra;
    seq[0] = 4'b0100; seq[1] = 4'b0110; seq[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      act(seq[i], o, e, l, el);
      n_cmp++;
      if (o !== e || l !== el || {map_rd_x, map_rd_y} !== 12'd0) begin
        n_err++;
        $display("FAIL turn_%0d: got %h lat %0d rd=%h expected %h lat %0d rd=000",
                 i, o, l, {map_rd_x, map_rd_y}, e, el);
      end
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        if (refresh || bump || busy) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
        n_err++;
        $display("FAIL turn_quiet_%0d: got %0d active cycles expected 0", i, extra);
      end
    end
  endtask

  // Face east into the wall at (6,2), then step back to (4,2)
  task automatic test_bump_and_back();
    logic [3:0] seq [4];
    logic [15:0] o, e;
    int l, el;
    seq[0] = 4'b0100; seq[1] = 4'b0100; seq[2] = 4'b0010; seq[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      act(seq[i], o, e, l, el);
      n_cmp++;
      if (o !== e || l !== el) begin
        n_err++;
        $display("FAIL bump_back_%0d: got %h lat %0d expected %h lat %0d", i, o, l, e, el);
      end
    end
  endtask

  // Walk west to x=0 and try once more: out of bounds must bump
  task automatic test_oob();
    logic [3:0] seq [7];
    logic [15:0] o, e;
    int l, el;
    seq[0] = 4'b1000; seq[1] = 4'b1000;
    for (int i = 2; i < 7; i++) seq[i] = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      act(seq[i], o, e, l, el);
      n_cmp++;
      if (o !== e || l !== el) begin
        n_err++;
        $display("FAIL oob_%0d: got %h lat %0d expected %h lat %0d", i, o, l, e, el);
      end
    end
    n_cmp++;
    if (map_rd_x !== 6'h3f) begin
      n_err++;
      $display("FAIL oob_rd_x: got %h expected 3f", map_rd_x);
    end
  endtask

  // Holding forward for 10 cycles produces exactly one move
  task automatic test_hold();
    logic [15:0] o, e;
    int l, el, n_ref, n_bmp;
    act(4'b0100, o, e, l, el);
    n_cmp++;
    if (o !== e || l !== el) begin
      n_err++;
      $display("FAIL hold_turn: got %h lat %0d expected %h lat %0d", o, l, e, el);
    end
    model_step(4'b0010, e, el);
    exp_q.push_back(e);
    n_ref = 0; n_bmp = 0;
    @(posedge clk); #1 key_pressed = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (refresh) n_ref++;
      if (bump) n_bmp++;
      if (i == 9) key_pressed = 4'b0000;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (n_ref !== 1 || n_bmp !== 0 || {px, py, direction} !== e[15:2]) begin
      n_err++;
      $display("FAIL hold_single: got refresh=%0d bump=%0d pos=%h expected 1 0 %h",
               n_ref, n_bmp, {px, py, direction}, e[15:2]);
    end
  endtask

  // Route from (0,1) to the exit, then check the sticky lock-out
  task automatic test_exit();
    logic [3:0] seq [$];
    logic [15:0] o, e;
    int l, el, act_cnt;
    logic [13:0] pos;
    seq.push_back(4'b0100);
    seq.push_back(4'b0010);
    seq.push_back(4'b0100);
    for (int i = 0; i < 18; i++) seq.push_back(4'b0010);
    seq.push_back(4'b1000);
    for (int i = 0; i < 8; i++) seq.push_back(4'b0010);
    foreach (seq[i]) begin
      act(seq[i], o, e, l, el);
      n_cmp++;
      if (o !== e || l !== el) begin
        n_err++;
        $display("FAIL exit_path_%0d: got %h lat %0d expected %h lat %0d", i, o, l, e, el);
      end
    end
    n_cmp++;
    if ({px, py, at_exit} !== {6'd9, 6'd19, 1'b0}) begin
      n_err++;
      $display("FAIL exit_arrive: got (%0d,%0d) at_exit=%b expected (9,19) 0", px, py, at_exit);
    end
    @(negedge clk);
    n_cmp++;
    if (at_exit !== 1'b1) begin
      n_err++;
      $display("FAIL exit_set: got at_exit=%b expected 1", at_exit);
    end
    pos = {px, py, direction};
    for (int k = 0; k < 2; k++) begin
      press(k == 0 ? 4'b1000 : 4'b0010);
      act_cnt = 0;
      repeat (6) begin
        @(negedge clk);
        if (refresh || bump || busy) act_cnt++;
      end
      n_cmp++;
      if (act_cnt !== 0 || {px, py, direction} !== pos || at_exit !== 1'b1) begin
        n_err++;
        $display("FAIL exit_lock_%0d: got active=%0d pos=%h at_exit=%b expected 0 %h 1",
                 k, act_cnt, {px, py, direction}, at_exit, pos);
      end
    end
    do_reset();
    n_cmp++;
    if ({at_exit, px, py} !== {1'b0, 6'd5, 6'd2}) begin
      n_err++;
      $display("FAIL exit_clear: got at_exit=%b pos=(%0d,%0d) expected 0 (5,2)", at_exit, px, py);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int y = 0; y < MAP_H; y++) tb_map[y] = '0;
    tb_map[2] = 11'b00001000000;
    tb_map[3] = 11'b10101000101;
    m_px = 5; m_py = 2; m_dir = 3;
    test_reset();
    test_move_latency();
    do_reset();
    test_turns();
    test_bump_and_back();
    test_oob();
    test_hold();
    test_exit();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
